// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request/acknowledge bus between a master and the SRAM controller.
//   i_cs    : request, held by the master until o_ack
//   i_we    : 1 = write, 0 = read
//   i_addr  : word address
//   i_data  : write data
//   i_sel   : byte-lane select for writes
//   o_data  : registered read data
//   o_ack   : one-cycle completion pulse
interface sram_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                    i_cs;
    logic                    i_we;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic [DATA_WIDTH-1:0]   i_data;
    logic [DATA_WIDTH/8-1:0] i_sel;
    logic [DATA_WIDTH-1:0]   o_data;
    logic                    o_ack;

    modport master (
        output i_cs, i_we, i_addr, i_data, i_sel,
        input  o_data, o_ack
    );

    modport slave (
        input  i_cs, i_we, i_addr, i_data, i_sel,
        output o_data, o_ack
    );
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: asynchronous-SRAM controller with setup / strobe / hold phases.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   bus            : request bus (slave side): cs/we/addr/data/sel in, data/ack out
//   o_sram_addr    : SRAM address pins
//   o_sram_data    : data to the pads, i_sram_data : data from the pads
//   o_sram_drive   : pad output enable
//   o_sram_cs_n, o_sram_we_n, o_sram_oe_n, o_sram_be_n : active-low SRAM strobes
// Every output is a flop; the next value of each is decoded from the next state.
module sram_ctrl #(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TURNAROUND  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    sram_ctrl_if.slave              bus,
    output logic [ADDR_WIDTH-1:0]   o_sram_addr,
    output logic [DATA_WIDTH-1:0]   o_sram_data,
    input  logic [DATA_WIDTH-1:0]   i_sram_data,
    output logic                    o_sram_drive,
    output logic                    o_sram_cs_n,
    output logic                    o_sram_we_n,
    output logic                    o_sram_oe_n,
    output logic [DATA_WIDTH/8-1:0] o_sram_be_n
);
    localparam int unsigned NumLanes = DATA_WIDTH / 8;
    localparam logic [3:0] AccessLast = 4'(WAIT_STATES);
    localparam logic [3:0] TurnLast   = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

    typedef enum logic [2:0] {StIdle, StTurn, StSetup, StAccess, StFinish} state_e;

    state_e                  r_state, w_state_d;
    logic [3:0]              r_cnt, w_cnt_d;
    logic                    r_we, w_we_d;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_d;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_d;
    logic [NumLanes-1:0]     r_sel, w_sel_d;
    logic                    r_last_read;
    logic                    w_capture;

    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_ack, w_ack_d;
    logic [ADDR_WIDTH-1:0]   r_sram_addr, w_sram_addr_d;
    logic [DATA_WIDTH-1:0]   r_sram_data, w_sram_data_d;
    logic                    r_drive, w_drive_d;
    logic                    r_cs_n, w_cs_n_d;
    logic                    r_we_n, w_we_n_d;
    logic                    r_oe_n, w_oe_n_d;
    logic [NumLanes-1:0]     r_be_n, w_be_n_d;

    // Next state and request latching
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_we_d    = r_we;
        w_addr_d  = r_addr;
        w_wdata_d = r_wdata;
        w_sel_d   = r_sel;
        case (r_state)
            StIdle: begin
                if (bus.i_cs) begin
                    w_we_d    = bus.i_we;
                    w_addr_d  = bus.i_addr;
                    w_wdata_d = bus.i_data;
                    w_sel_d   = bus.i_sel;
                    w_cnt_d   = 4'd0;
                    // Give the SRAM time to release the bus after a read
                    if (bus.i_we && r_last_read && (TURNAROUND != 0)) begin
                        w_state_d = StTurn;
                    end else begin
                        w_state_d = StSetup;
                    end
                end
            end
            StTurn: begin
                if (r_cnt == TurnLast) begin
                    w_state_d = StSetup;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            StSetup: begin
                w_state_d = StAccess;
                w_cnt_d   = 4'd0;
            end
            StAccess: begin
                if (r_cnt == AccessLast) begin
                    w_state_d = StFinish;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            StFinish: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Read data is sampled on the edge that closes the last strobe cycle
    assign w_capture = (r_state == StAccess) && (r_cnt == AccessLast) && !r_we;

    // Pin values for the cycle we are about to enter
    always_comb begin
        w_ack_d       = 1'b0;
        w_cs_n_d      = 1'b1;
        w_we_n_d      = 1'b1;
        w_oe_n_d      = 1'b1;
        w_be_n_d      = '1;
        w_drive_d     = 1'b0;
        w_sram_addr_d = r_sram_addr;
        w_sram_data_d = r_sram_data;
        case (w_state_d)
            StSetup: begin
                w_cs_n_d      = 1'b0;
                w_sram_addr_d = w_addr_d;
                if (w_we_d) begin
                    w_drive_d     = 1'b1;
                    w_sram_data_d = w_wdata_d;
                    w_be_n_d      = ~w_sel_d;
                end else begin
                    w_oe_n_d = 1'b0;
                    w_be_n_d = '0;
                end
            end
            StAccess: begin
                w_cs_n_d = 1'b0;
                if (w_we_d) begin
                    w_we_n_d  = 1'b0;
                    w_drive_d = 1'b1;
                    w_be_n_d  = ~w_sel_d;
                end else begin
                    w_oe_n_d = 1'b0;
                    w_be_n_d = '0;
                end
            end
            StFinish: begin
                w_ack_d = 1'b1;
                // Writes keep cs, data and lanes for a hold cycle after we_n rises
                if (w_we_d) begin
                    w_cs_n_d  = 1'b0;
                    w_drive_d = 1'b1;
                    w_be_n_d  = ~w_sel_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_sel       <= '0;
            r_last_read <= 1'b0;
            r_data      <= '0;
            r_ack       <= 1'b0;
            r_sram_addr <= '0;
            r_sram_data <= '0;
            r_drive     <= 1'b0;
            r_cs_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_be_n      <= '1;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_we        <= w_we_d;
            r_addr      <= w_addr_d;
            r_wdata     <= w_wdata_d;
            r_sel       <= w_sel_d;
            if (r_state == StFinish) begin
                r_last_read <= !r_we;
            end
            if (w_capture) begin
                r_data <= i_sram_data;
            end
            r_ack       <= w_ack_d;
            r_sram_addr <= w_sram_addr_d;
            r_sram_data <= w_sram_data_d;
            r_drive     <= w_drive_d;
            r_cs_n      <= w_cs_n_d;
            r_we_n      <= w_we_n_d;
            r_oe_n      <= w_oe_n_d;
            r_be_n      <= w_be_n_d;
        end
    end

    assign bus.o_data   = r_data;
    assign bus.o_ack    = r_ack;
    assign o_sram_addr  = r_sram_addr;
    assign o_sram_data  = r_sram_data;
    assign o_sram_drive = r_drive;
    assign o_sram_cs_n  = r_cs_n;
    assign o_sram_we_n  = r_we_n;
    assign o_sram_oe_n  = r_oe_n;
    assign o_sram_be_n  = r_be_n;
endmodule
